shr_tx_scheduler: RTL
=====================

Name: shr_tx_scheduler

Overview:
- Sequences the serial shift-register transmitter: decides when a frame is shifted out and which pattern it carries (captured JTAG data, all-zeros clear, or all-ones).
- Arbitrates three request sources, all already synchronised to clk_in: send, clear and clear-to-one.
- Handles repeated frames with a programmable inter-frame gap, abort, and a watchdog on the transmitter's done handshake.
- Sits between the virtual-key/JTAG control logic and the dout/sync/clk shifter, which runs on the divided clock.

Parameters:
- LEN_W, 10, width of the frame length (bits per frame).
- REP_W, 8, width of the repeat count.
- GAP_W, 8, width of the inter-frame gap count.
- TMO_W, 14, width of the watchdog counter in WAIT_DONE.

Ports:
- clk_in  input  1  divided system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_send  input  1  level request: transmit the data register; rising edge is acted on.
- req_clr  input  1  level request: transmit an all-zeros frame; rising edge is acted on.
- req_one  input  1  level request: transmit an all-ones frame; rising edge is acted on.
- abort  input  1  pulse: stop the sequence and drop pending requests.
- err_clr  input  1  pulse: clears the sticky error flags.
- seq_length  input  LEN_W  frame length in bits.
- repeat_cnt  input  REP_W  extra frames after the first; 0 means a single frame.
- gap_cycles  input  GAP_W  idle clk_in cycles between repeated frames.
- tx_done  input  1  one-cycle pulse from the shifter when a frame completes.
- tx_start  output  1  one-cycle pulse that starts the shifter.
- tx_sel  output  2  pattern select: 00 = data, 01 = zeros, 10 = ones.
- tx_len  output  LEN_W  frame length captured at grant.
- busy  output  1  high in any state other than IDLE.
- frame_cnt  output  16  number of completed frames; saturates at 16'hFFFF.
- err_len  output  1  sticky: a request was granted with seq_length = 0.
- err_tmo  output  1  sticky: the watchdog expired in WAIT_DONE.

Behaviour:
- Reset values:
  - State = IDLE.
  - tx_start = 0, tx_sel = 00, tx_len = 0, busy = 0, frame_cnt = 0, err_len = 0, err_tmo = 0.
  - Pending bits = 0.
  - Request edge registers = 0. A request held high through reset release therefore registers an edge on the first cycle.
- Edge detection and pending:
  - A registered rising edge on a request sets its pending bit in that same cycle.
  - Repeated edges of the same kind merge into one pending bit.
  - Requests arriving while busy stay pending and are served after the current sequence finishes.
- Priority at grant: clr > one > send.
  - Only the granted pending bit is cleared; the others stay pending.
- States:
  - IDLE: if any bit is pending, capture tx_sel, tx_len = seq_length and rem = repeat_cnt, clear the granted bit, then go to START.
    - If seq_length = 0 at grant: set err_len, clear the granted bit, stay in IDLE, no tx_start.
  - START: tx_start = 1 for exactly one cycle, then go to WAIT_DONE.
    - Latency: request edge at cycle n gives tx_start at cycle n+2.
  - WAIT_DONE: the watchdog counts up.
    - On tx_done: increment frame_cnt (saturating) and clear the watchdog.
    - Then, if rem > 0, decrement rem and go to GAP, or straight to START when gap_cycles = 0. Otherwise go to IDLE.
    - If the watchdog reaches all-ones before tx_done: set err_tmo, set rem = 0, go to IDLE.
  - GAP: load gap_cycles on entry and count down. Go to START in the cycle after the counter reads 1, so exactly gap_cycles idle cycles separate tx_done from the next tx_start.
- tx_sel and tx_len are held stable from grant through the whole sequence, including repeats. Inputs changing mid-sequence have no effect.
- tx_done outside WAIT_DONE is ignored.
- abort:
  - Clears all pending bits in every state.
  - In GAP: go to IDLE next cycle.
  - In START or WAIT_DONE: rem = 0. The frame already issued completes normally, counts toward frame_cnt, and the block then returns to IDLE. The shifter is never cut mid-frame.
  - A request edge in the same cycle as abort is dropped.
- err_clr clears both error flags. If an error sets in the same cycle as err_clr, the set wins.
- Async rst mid-sequence returns every output to its reset value immediately. The shifter must be reset by the same rst.

Test Plan:
- Single send: seq_length = 24, repeat_cnt = 0, req_send rises at cycle 10 -> tx_start high only at cycle 12, tx_sel = 00, tx_len = 24; tx_done at cycle 40 -> busy low at cycle 41, frame_cnt = 1.
- Repeats with gap: repeat_cnt = 2, gap_cycles = 5, shifter model returns tx_done 30 cycles after each start -> exactly 3 tx_start pulses, each 6 cycles after the previous tx_done; frame_cnt = 3.
- Simultaneous requests: req_clr, req_one and req_send rise in the same cycle -> frames served in order tx_sel = 01, then 10, then 00; frame_cnt = 3.
- Abort in GAP with repeat_cnt = 4 after the first frame -> no further tx_start, IDLE next cycle, frame_cnt = 1. Abort in WAIT_DONE -> the current tx_done is still counted, then IDLE.
- Zero length: seq_length = 0 with req_send -> no tx_start, err_len = 1, busy stays 0; err_clr -> err_len = 0.
- Watchdog: TMO_W = 4, no tx_done -> err_tmo = 1 after 15 WAIT_DONE cycles, return to IDLE, a pending req_one is then served normally. Async rst asserted mid-frame -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/shr_tx_scheduler.sv
// shr_tx_scheduler: frame sequencer in front of the serial shift-register
// transmitter; arbitrates clear/one/send, repeats frames, guards tx_done.
module shr_tx_scheduler #(
    parameter int LEN_W = 10,
    parameter int REP_W = 8,
    parameter int GAP_W = 8,
    parameter int TMO_W = 14
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req_send,
    input  logic             req_clr,
    input  logic             req_one,
    input  logic             abort,
    input  logic             err_clr,
    input  logic [LEN_W-1:0] seq_length,
    input  logic [REP_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic             tx_done,
    output logic             tx_start,
    output logic [1:0]       tx_sel,
    output logic [LEN_W-1:0] tx_len,
    output logic             busy,
    output logic [15:0]      frame_cnt,
    output logic             err_len,
    output logic             err_tmo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_ZERO = 2'b01;
    localparam logic [1:0] SEL_ONE  = 2'b10;

    state_t           state_q, state_d;
    // bit 0 = clr, bit 1 = one, bit 2 = send (also the priority order)
    logic [2:0]       req_q, req_d;
    logic [2:0]       pend_q, pend_d;
    logic [2:0]       rise;
    logic [2:0]       gnt;
    logic [REP_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic [TMO_W-1:0] wd_q, wd_d, wd_inc;
    logic             tx_start_q, tx_start_d;
    logic [1:0]       tx_sel_q, tx_sel_d;
    logic [LEN_W-1:0] tx_len_q, tx_len_d;
    logic             busy_q, busy_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             err_len_q, err_len_d;
    logic             err_tmo_q, err_tmo_d;
    logic             set_len, set_tmo, take;

    // Rising-edge detect on requests and fixed-priority pick of a pending bit
    always_comb begin
        req_d = {req_send, req_one, req_clr};
        rise  = req_d & ~req_q;
        gnt   = 3'b000;
        priority case (1'b1)
            pend_q[0]: gnt = 3'b001;
            pend_q[1]: gnt = 3'b010;
            pend_q[2]: gnt = 3'b100;
            default:   gnt = 3'b000;
        endcase
    end

    // Sequencer next state; pattern, length, repeats and gap frozen at grant
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        gap_d       = gap_q;
        gcnt_d      = gcnt_q;
        wd_d        = wd_q;
        tx_sel_d    = tx_sel_q;
        tx_len_d    = tx_len_q;
        frame_cnt_d = frame_cnt_q;
        set_len     = 1'b0;
        set_tmo     = 1'b0;
        take        = 1'b0;
        wd_inc      = wd_q + 1'b1;
        unique case (state_q)
            S_IDLE: begin
                if (!abort && (pend_q != 3'b000)) begin
                    take = 1'b1;
                    if (seq_length == '0) begin
                        set_len = 1'b1;
                    end else begin
                        state_d  = S_START;
                        tx_len_d = seq_length;
                        rem_d    = repeat_cnt;
                        gap_d    = gap_cycles;
                        tx_sel_d = gnt[0] ? SEL_ZERO :
                                   (gnt[1] ? SEL_ONE : SEL_DATA);
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
                wd_d    = '0;
                if (abort) rem_d = '0;
            end
            S_WAIT: begin
                if (tx_done) begin
                    wd_d = '0;
                    if (frame_cnt_q != 16'hFFFF)
                        frame_cnt_d = frame_cnt_q + 16'd1;
                    if (abort || (rem_q == '0)) begin
                        rem_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        rem_d = rem_q - 1'b1;
                        if (gap_q == '0) begin
                            state_d = S_START;
                        end else begin
                            state_d = S_GAP;
                            gcnt_d  = gap_q;
                        end
                    end
                end else if (&wd_inc) begin
                    set_tmo = 1'b1;
                    rem_d   = '0;
                    wd_d    = '0;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_inc;
                    if (abort) rem_d = '0;
                end
            end
            S_GAP: begin
                if (abort) begin
                    rem_d   = '0;
                    state_d = S_IDLE;
                end else if (gcnt_q == GAP_W'(1)) begin
                    state_d = S_START;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
        endcase
        // abort also swallows any edge arriving with it
        pend_d = abort ? 3'b000 :
                 ((pend_q & ~(take ? gnt : 3'b000)) | rise);
        tx_start_d = (state_d == S_START);
        busy_d     = (state_d != S_IDLE);
        err_len_d  = set_len | (err_len_q & ~err_clr);
        err_tmo_d  = set_tmo | (err_tmo_q & ~err_clr);
    end

    // State and registered outputs, cleared asynchronously by rst
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            pend_q      <= '0;
            rem_q       <= '0;
            gap_q       <= '0;
            gcnt_q      <= '0;
            wd_q        <= '0;
            tx_start_q  <= 1'b0;
            tx_sel_q    <= SEL_DATA;
            tx_len_q    <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            err_len_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            pend_q      <= pend_d;
            rem_q       <= rem_d;
            gap_q       <= gap_d;
            gcnt_q      <= gcnt_d;
            wd_q        <= wd_d;
            tx_start_q  <= tx_start_d;
            tx_sel_q    <= tx_sel_d;
            tx_len_q    <= tx_len_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_len_q   <= err_len_d;
            err_tmo_q   <= err_tmo_d;
        end
    end

    assign tx_start  = tx_start_q;
    assign tx_sel    = tx_sel_q;
    assign tx_len    = tx_len_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign err_len   = err_len_q;
    assign err_tmo   = err_tmo_q;

endmodule
